// File: rtl/controlmux.sv
// Control-word mux select shared by the hazard controller and the forwarder.
package controlmux;

    // ZERO injects an all-zero control word (bubble) into ID/EX;
    // NORMAL passes the decoded control word through.
    typedef enum logic [0:0] {
        CMUX_ZERO   = 1'b0,
        CMUX_NORMAL = 1'b1
    } controlmux_sel_t;

endpackage

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller for the 5-stage RV32I core.
// Inserts bubbles for load-use (1) and load-to-branch (2) dependencies,
// freezes the whole pipeline on outstanding memory accesses, flushes IF/ID
// on taken branches and keeps saturating stall/bubble counters.
module hazard_ctrl #(
    parameter int PERF_W = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [4:0]                   ID_rs1_i,
    input  logic [4:0]                   ID_rs2_i,
    input  logic                         ID_uses_rs1_i,
    input  logic                         ID_uses_rs2_i,
    input  logic                         ID_is_branch_i,
    input  logic                         ID_br_taken_i,
    input  logic [4:0]                   ID_EX_rd_i,
    input  logic                         EX_load_regfile_i,
    input  logic                         EX_is_load_i,
    input  logic                         imem_read_i,
    input  logic                         imem_resp_i,
    input  logic                         dmem_access_i,
    input  logic                         dmem_resp_i,
    output logic                         pc_load_o,
    output logic                         IF_ID_load_o,
    output logic                         ID_EX_load_o,
    output logic                         EX_MEM_load_o,
    output logic                         MEM_WB_load_o,
    output logic                         IF_ID_flush_o,
    output controlmux::controlmux_sel_t  ID_HD_controlmux_sel_o,
    output logic [PERF_W-1:0]            stall_cycles_o,
    output logic [PERF_W-1:0]            bubble_cycles_o
);

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_bub_cnt;
    logic                w_bub_cnt_nxt;
    logic [PERF_W-1:0]   r_stall_cnt;
    logic [PERF_W-1:0]   r_bubble_cnt;
    logic                w_mstall;
    logic                w_dep;
    logic                w_rs1_hit;
    logic                w_rs2_hit;
    logic                w_inc_stall;
    logic                w_inc_bubble;

    // Hazard detection: memory freeze and load dependency in decode.
    always_comb begin
        w_mstall  = (imem_read_i & ~imem_resp_i) | (dmem_access_i & ~dmem_resp_i);
        w_rs1_hit = ID_uses_rs1_i & (ID_rs1_i == ID_EX_rd_i);
        w_rs2_hit = ID_uses_rs2_i & (ID_rs2_i == ID_EX_rd_i);
        // x0 is never a real producer, so a load to x0 must not stall.
        w_dep     = EX_load_regfile_i & EX_is_load_i & (|ID_EX_rd_i) & (w_rs1_hit | w_rs2_hit);
    end

    // FSM state and remaining-bubble counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= RUN;
            r_bub_cnt <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bub_cnt <= w_bub_cnt_nxt;
        end
    end

    // Next-state and pipeline control; memory freeze wins over bubbles,
    // bubbles win over taken-branch flush.
    always_comb begin
        w_state_nxt            = r_state;
        w_bub_cnt_nxt          = r_bub_cnt;
        pc_load_o              = 1'b1;
        IF_ID_load_o           = 1'b1;
        ID_EX_load_o           = 1'b1;
        EX_MEM_load_o          = 1'b1;
        MEM_WB_load_o          = 1'b1;
        IF_ID_flush_o          = 1'b0;
        ID_HD_controlmux_sel_o = controlmux::CMUX_NORMAL;
        w_inc_stall            = 1'b0;
        w_inc_bubble           = 1'b0;

        if (!rst) begin
            // Hold everything and feed bubbles while in reset.
            pc_load_o              = 1'b0;
            IF_ID_load_o           = 1'b0;
            ID_EX_load_o           = 1'b0;
            EX_MEM_load_o          = 1'b0;
            MEM_WB_load_o          = 1'b0;
            ID_HD_controlmux_sel_o = controlmux::CMUX_ZERO;
        end else if (w_mstall) begin
            // Whole pipeline frozen; FSM holds its place.
            pc_load_o     = 1'b0;
            IF_ID_load_o  = 1'b0;
            ID_EX_load_o  = 1'b0;
            EX_MEM_load_o = 1'b0;
            MEM_WB_load_o = 1'b0;
            w_inc_stall   = 1'b1;
        end else if (r_state == BUBBLE) begin
            // Second bubble of a load-to-branch; dep is not re-checked here.
            pc_load_o              = 1'b0;
            IF_ID_load_o           = 1'b0;
            ID_HD_controlmux_sel_o = controlmux::CMUX_ZERO;
            w_inc_bubble           = 1'b1;
            w_bub_cnt_nxt          = r_bub_cnt - 1'b1;
            w_state_nxt            = RUN;
        end else if (w_dep) begin
            // Branch operands are invalid this cycle, so br_taken is ignored.
            pc_load_o              = 1'b0;
            IF_ID_load_o           = 1'b0;
            ID_HD_controlmux_sel_o = controlmux::CMUX_ZERO;
            w_inc_bubble           = 1'b1;
            if (ID_is_branch_i) begin
                w_state_nxt   = BUBBLE;
                w_bub_cnt_nxt = 1'b1;
            end
        end else begin
            IF_ID_flush_o = ID_is_branch_i & ID_br_taken_i;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_inc_stall && (r_stall_cnt != {PERF_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + PERF_W'(1);
            if (w_inc_bubble && (r_bubble_cnt != {PERF_W{1'b1}}))
                r_bubble_cnt <= r_bubble_cnt + PERF_W'(1);
        end
    end

    assign stall_cycles_o  = r_stall_cnt;
    assign bubble_cycles_o = r_bubble_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_hazard_ctrl;

    localparam int PW  = 4;
    localparam int MAX = (1 << PW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [4:0] ID_rs1_i, ID_rs2_i, ID_EX_rd_i;
    logic ID_uses_rs1_i, ID_uses_rs2_i, ID_is_branch_i, ID_br_taken_i;
    logic EX_load_regfile_i, EX_is_load_i;
    logic imem_read_i, imem_resp_i, dmem_access_i, dmem_resp_i;
    logic pc_load_o, IF_ID_load_o, ID_EX_load_o, EX_MEM_load_o, MEM_WB_load_o, IF_ID_flush_o;
    controlmux::controlmux_sel_t sel_o;
    logic [PW-1:0] stall_cycles_o, bubble_cycles_o;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Model state: extra bubbles still owed, and the two counters.
    int m_owed  = 0;
    int m_stall = 0;
    int m_bub   = 0;

    hazard_ctrl #(.PERF_W(PW)) dut (
        .clk(clk), .rst(rst),
        .ID_rs1_i(ID_rs1_i), .ID_rs2_i(ID_rs2_i),
        .ID_uses_rs1_i(ID_uses_rs1_i), .ID_uses_rs2_i(ID_uses_rs2_i),
        .ID_is_branch_i(ID_is_branch_i), .ID_br_taken_i(ID_br_taken_i),
        .ID_EX_rd_i(ID_EX_rd_i),
        .EX_load_regfile_i(EX_load_regfile_i), .EX_is_load_i(EX_is_load_i),
        .imem_read_i(imem_read_i), .imem_resp_i(imem_resp_i),
        .dmem_access_i(dmem_access_i), .dmem_resp_i(dmem_resp_i),
        .pc_load_o(pc_load_o), .IF_ID_load_o(IF_ID_load_o),
        .ID_EX_load_o(ID_EX_load_o), .EX_MEM_load_o(EX_MEM_load_o),
        .MEM_WB_load_o(MEM_WB_load_o), .IF_ID_flush_o(IF_ID_flush_o),
        .ID_HD_controlmux_sel_o(sel_o),
        .stall_cycles_o(stall_cycles_o), .bubble_cycles_o(bubble_cycles_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_mstall();
        return (imem_read_i && !imem_resp_i) || (dmem_access_i && !dmem_resp_i);
    endfunction

    function automatic bit model_dep();
        bit hit;
        hit = (ID_uses_rs1_i && ID_rs1_i == ID_EX_rd_i) || (ID_uses_rs2_i && ID_rs2_i == ID_EX_rd_i);
        return EX_load_regfile_i && EX_is_load_i && (ID_EX_rd_i != 5'd0) && hit;
    endfunction

    // Model: counters and owed bubbles advance on the clock, clear on reset.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_owed = 0; m_stall = 0; m_bub = 0;
        end else if (model_mstall()) begin
            if (m_stall < MAX) m_stall = m_stall + 1;
        end else if (m_owed > 0) begin
            if (m_bub < MAX) m_bub = m_bub + 1;
            m_owed = m_owed - 1;
        end else if (model_dep()) begin
            if (m_bub < MAX) m_bub = m_bub + 1;
            m_owed = ID_is_branch_i ? 1 : 0;
        end
    end

    // Compare every output against the model mid-cycle.
    always @(negedge clk) begin : cmp
        bit e_front, e_back, e_flush, e_sel;
        if (cmp_en) begin
            if (!rst) begin
                e_front = 0; e_back = 0; e_flush = 0; e_sel = 0;
            end else if (model_mstall()) begin
                e_front = 0; e_back = 0; e_flush = 0; e_sel = 1;
            end else if (m_owed > 0 || model_dep()) begin
                e_front = 0; e_back = 1; e_flush = 0; e_sel = 0;
            end else begin
                e_front = 1; e_back = 1; e_sel = 1;
                e_flush = ID_is_branch_i && ID_br_taken_i;
            end
            chk("pc_load", 32'(pc_load_o), 32'(e_front));
            chk("IF_ID_load", 32'(IF_ID_load_o), 32'(e_front));
            chk("ID_EX_load", 32'(ID_EX_load_o), 32'(e_back));
            chk("EX_MEM_load", 32'(EX_MEM_load_o), 32'(e_back));
            chk("MEM_WB_load", 32'(MEM_WB_load_o), 32'(e_back));
            chk("flush", 32'(IF_ID_flush_o), 32'(e_flush));
            chk("sel", 32'(sel_o), 32'(e_sel));
            chk("stall_cycles", 32'(stall_cycles_o), 32'(m_stall));
            chk("bubble_cycles", 32'(bubble_cycles_o), 32'(m_bub));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ID_rs1_i = 0; ID_rs2_i = 0; ID_EX_rd_i = 0;
        ID_uses_rs1_i = 0; ID_uses_rs2_i = 0; ID_is_branch_i = 0; ID_br_taken_i = 0;
        EX_load_regfile_i = 0; EX_is_load_i = 0;
        imem_read_i = 0; imem_resp_i = 0; dmem_access_i = 0; dmem_resp_i = 0;
    endtask

    task automatic ex_load(input logic [4:0] rd);
        EX_load_regfile_i = 1; EX_is_load_i = 1; ID_EX_rd_i = rd;
    endtask

    task automatic ex_bubble();
        EX_load_regfile_i = 0; EX_is_load_i = 0; ID_EX_rd_i = 0;
    endtask

    task automatic do_reset();
        cyc();
        rst = 0;
        idle();
        cyc();
        rst = 1;
    endtask

    initial begin
        idle();
        cyc();
        cmp_en = 1;
        // Reset state
        chk("rst_pc_load", 32'(pc_load_o), 0);
        chk("rst_sel", 32'(sel_o), 32'(controlmux::CMUX_ZERO));
        chk("rst_stall", 32'(stall_cycles_o), 0);
        rst = 1;

        // Load-use: one bubble
        ex_load(5'd5); ID_uses_rs1_i = 1; ID_rs1_i = 5'd5;
        #1 chk("lu_pc_load", 32'(pc_load_o), 0);
        chk("lu_sel", 32'(sel_o), 32'(controlmux::CMUX_ZERO));
        cyc();
        ex_bubble();
        #1 chk("lu_after_pc_load", 32'(pc_load_o), 1);
        chk("lu_bubbles", 32'(bubble_cycles_o), 1);

        // Load-to-branch: two bubbles, then the taken flush
        do_reset();
        ex_load(5'd5); ID_uses_rs2_i = 1; ID_rs2_i = 5'd5;
        ID_is_branch_i = 1; ID_br_taken_i = 1;
        #1 chk("lb1_flush", 32'(IF_ID_flush_o), 0);
        chk("lb1_pc_load", 32'(pc_load_o), 0);
        cyc();
        ex_bubble();
        #1 chk("lb2_pc_load", 32'(pc_load_o), 0);
        chk("lb2_flush", 32'(IF_ID_flush_o), 0);
        cyc();
        #1 chk("lb3_flush", 32'(IF_ID_flush_o), 1);
        chk("lb3_pc_load", 32'(pc_load_o), 1);
        chk("lb_bubbles", 32'(bubble_cycles_o), 2);

        // x0 load and ALU producer never stall
        idle();
        ex_load(5'd0); ID_uses_rs1_i = 1; ID_rs1_i = 5'd0;
        #1 chk("x0_pc_load", 32'(pc_load_o), 1);
        chk("x0_sel", 32'(sel_o), 32'(controlmux::CMUX_NORMAL));
        cyc();
        EX_is_load_i = 0; ID_EX_rd_i = 5'd7; ID_rs1_i = 5'd7;
        #1 chk("alu_pc_load", 32'(pc_load_o), 1);
        chk("alu_sel", 32'(sel_o), 32'(controlmux::CMUX_NORMAL));

        // Memory stall inside BUBBLE
        do_reset();
        ex_load(5'd5); ID_uses_rs2_i = 1; ID_rs2_i = 5'd5; ID_is_branch_i = 1;
        cyc();
        ex_bubble(); dmem_access_i = 1; dmem_resp_i = 0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("ms_pc_load", 32'(pc_load_o), 0);
            chk("ms_MEM_WB_load", 32'(MEM_WB_load_o), 0);
            cyc();
        end
        dmem_resp_i = 1;
        #1 chk("ms_resume_pc_load", 32'(pc_load_o), 0);
        chk("ms_resume_sel", 32'(sel_o), 32'(controlmux::CMUX_ZERO));
        cyc();
        dmem_access_i = 0; dmem_resp_i = 0;
        #1 chk("ms_stalls", 32'(stall_cycles_o), 4);
        chk("ms_bubbles", 32'(bubble_cycles_o), 2);
        chk("ms_end_pc_load", 32'(pc_load_o), 1);

        // Asynchronous reset in the middle of BUBBLE
        do_reset();
        ex_load(5'd5); ID_uses_rs1_i = 1; ID_rs1_i = 5'd5; ID_is_branch_i = 1;
        cyc();
        idle();
        rst = 0;
        #1 chk("ar_bubbles", 32'(bubble_cycles_o), 0);
        chk("ar_ID_EX_load", 32'(ID_EX_load_o), 0);
        chk("ar_sel", 32'(sel_o), 32'(controlmux::CMUX_ZERO));
        cyc();
        rst = 1;
        #1 chk("ar_post_pc_load", 32'(pc_load_o), 1);
        cyc();
        chk("ar_post2_pc_load", 32'(pc_load_o), 1);

        // Stall counter saturates
        do_reset();
        imem_read_i = 1; imem_resp_i = 0;
        for (int i = 0; i < 20; i++) cyc();
        chk("sat_stall", 32'(stall_cycles_o), 32'hF);
        idle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cyc();
            rst               = ($urandom_range(0, 199) != 0);
            ID_rs1_i          = 5'($urandom_range(0, 3));
            ID_rs2_i          = 5'($urandom_range(0, 3));
            ID_EX_rd_i        = 5'($urandom_range(0, 3));
            ID_uses_rs1_i     = 1'($urandom_range(0, 1));
            ID_uses_rs2_i     = 1'($urandom_range(0, 1));
            ID_is_branch_i    = 1'($urandom_range(0, 1));
            ID_br_taken_i     = 1'($urandom_range(0, 1));
            EX_is_load_i      = 1'($urandom_range(0, 1));
            EX_load_regfile_i = ($urandom_range(0, 3) != 0);
            imem_read_i       = ($urandom_range(0, 3) == 0);
            imem_resp_i       = 1'($urandom_range(0, 1));
            dmem_access_i     = ($urandom_range(0, 3) == 0);
            dmem_resp_i       = 1'($urandom_range(0, 1));
        end
        cyc();
        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
